// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 BCM scan scheduler.
// Holds the scheduler state encoding, the default geometry and the width of
// the per-plane on-time counter.
package hub75_pkg;

  localparam int unsigned DEF_COLS        = 64;
  localparam int unsigned DEF_ROW_BITS    = 4;
  localparam int unsigned DEF_PLANES      = 4;
  localparam int unsigned DEF_BRIGHT_BITS = 8;

  // (brightness+1) << plane never exceeds this width.
  localparam int unsigned ON_TIME_W = DEF_BRIGHT_BITS + DEF_PLANES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_DRAIN,
    S_LATCH,
    S_DISPLAY,
    S_BLANK
  } state_t;

endpackage

// File: rtl/hub75_scan_scheduler_if.sv
// Signal bundle between the scan scheduler, the frame-RAM read port, the
// write-side swap logic and the HUB75 pins.
//   master : the scheduler (drives addresses, pin controls, swap_ack)
//   slave  : the environment (drives enable, brightness, swap_req)
interface hub75_scan_scheduler_if
  import hub75_pkg::*;
#(
  parameter int unsigned COLS        = DEF_COLS,
  parameter int unsigned ROW_BITS    = DEF_ROW_BITS,
  parameter int unsigned PLANES      = DEF_PLANES,
  parameter int unsigned BRIGHT_BITS = DEF_BRIGHT_BITS
);
  localparam int unsigned COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;

  logic                      enable;
  logic [BRIGHT_BITS-1:0]    brightness;
  logic                      swap_req;
  logic                      swap_ack;
  logic                      display_buf;
  logic [ROW_BITS+COL_W-1:0] rd_addr;
  logic [PLANE_W-1:0]        rd_plane;
  logic                      shift_en;
  logic [ROW_BITS-1:0]       hub75_addr;
  logic                      hub75_latch;
  logic                      hub75_oe;
  logic                      frame_start;

  modport master (
    input  enable, brightness, swap_req,
    output swap_ack, display_buf, rd_addr, rd_plane, shift_en,
           hub75_addr, hub75_latch, hub75_oe, frame_start
  );

  modport slave (
    output enable, brightness, swap_req,
    input  swap_ack, display_buf, rd_addr, rd_plane, shift_en,
           hub75_addr, hub75_latch, hub75_oe, frame_start
  );

endinterface

// File: rtl/hub75_on_timer.sv
// Loadable down-counter timing the OE-low window of one bit-plane.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : load value_i into the counter
//   value_i    : on-time in cycles (>= 1)
//   en_i       : count down one per cycle
//   done_o     : high in the last counted cycle
module hub75_on_timer
#(
  parameter int unsigned W = hub75_pkg::ON_TIME_W
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // <= 1 rather than == 1 so a zero load can never stall DISPLAY.
  assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/hub75_scan_scheduler.sv
// HUB75 refresh sequencer using binary-coded modulation.
// Per row and bit-plane: shift COLS pixels out of frame RAM, drain the RAM
// latency, latch, hold OE low for (brightness+1) << plane cycles, blank.
// Owns the double-buffer flip, taken only at frame end.
//   clk, reset : clock, synchronous active-high reset
//   bus        : hub75_scan_scheduler_if.master (RAM read side, HUB75 pins,
//                enable/brightness, swap handshake)
module hub75_scan_scheduler
  import hub75_pkg::*;
#(
  parameter int unsigned COLS        = DEF_COLS,
  parameter int unsigned ROW_BITS    = DEF_ROW_BITS,
  parameter int unsigned PLANES      = DEF_PLANES,
  parameter int unsigned BRIGHT_BITS = DEF_BRIGHT_BITS
)(
  input  logic                   clk,
  input  logic                   reset,
  hub75_scan_scheduler_if.master bus
);

  localparam int unsigned COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int unsigned OTW     = BRIGHT_BITS + PLANES;

  state_t                 state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_BITS-1:0]    row_q, row_d;
  logic [PLANE_W-1:0]     plane_q, plane_d;
  logic [BRIGHT_BITS-1:0] bright_q, bright_d;
  logic [ROW_BITS-1:0]    haddr_q, haddr_d;
  logic                   pending_q, pending_d;
  logic                   disp_q, disp_d;
  logic                   ack_q, ack_d;
  logic                   fs_q, fs_d;
  logic                   latch_q, latch_d;
  logic                   oe_q, oe_d;
  logic                   shen_q;
  logic                   frame_end;

  logic [OTW-1:0] bright_ext;
  logic [OTW-1:0] on_time;
  logic           tmr_load, tmr_en, tmr_done;

  assign bright_ext = OTW'(bright_q) + OTW'(1);
  assign on_time    = bright_ext << plane_q;
  assign tmr_load   = (state_q == S_LATCH);
  assign tmr_en     = (state_q == S_DISPLAY);

  hub75_on_timer #(.W(OTW)) u_on_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (tmr_load),
    .value_i (on_time),
    .en_i    (tmr_en),
    .done_o  (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    plane_d   = plane_q;
    bright_d  = bright_q;
    haddr_d   = haddr_q;
    disp_d    = disp_q;
    ack_d     = 1'b0;
    fs_d      = 1'b0;
    frame_end = 1'b0;
    pending_d = pending_q | bus.swap_req;

    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          state_d  = S_SHIFT;
          row_d    = '0;
          plane_d  = '0;
          col_d    = '0;
          bright_d = bus.brightness;
          fs_d     = 1'b1;
        end
      end
      S_SHIFT: begin
        if (col_q == COL_W'(COLS - 1)) begin
          col_d   = '0;
          state_d = S_DRAIN;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Address settles while OE is still high, one cycle ahead of latch.
        haddr_d = row_q;
        state_d = S_LATCH;
      end
      S_LATCH: state_d = S_DISPLAY;
      S_DISPLAY: begin
        if (tmr_done) state_d = S_BLANK;
      end
      S_BLANK: begin
        if (plane_q == PLANE_W'(PLANES - 1)) begin
          plane_d   = '0;
          row_d     = row_q + 1'b1;
          frame_end = (row_q == '1);
        end else begin
          plane_d = plane_q + 1'b1;
        end
        // A request arriving in this very cycle joins the flip.
        if (frame_end && (pending_q || bus.swap_req)) begin
          disp_d    = ~disp_q;
          ack_d     = 1'b1;
          pending_d = 1'b0;
        end
        if (bus.enable) begin
          state_d  = S_SHIFT;
          bright_d = bus.brightness;
          fs_d     = frame_end;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    oe_d    = (state_d != S_DISPLAY);
    latch_d = (state_d == S_LATCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      plane_q   <= '0;
      bright_q  <= '0;
      haddr_q   <= '0;
      pending_q <= 1'b0;
      disp_q    <= 1'b0;
      ack_q     <= 1'b0;
      fs_q      <= 1'b0;
      latch_q   <= 1'b0;
      oe_q      <= 1'b1;
      shen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      plane_q   <= plane_d;
      bright_q  <= bright_d;
      haddr_q   <= haddr_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      ack_q     <= ack_d;
      fs_q      <= fs_d;
      latch_q   <= latch_d;
      oe_q      <= oe_d;
      // RAM read data lags the address by one cycle.
      shen_q    <= (state_q == S_SHIFT);
    end
  end

  assign bus.rd_addr     = {row_q, col_q};
  assign bus.rd_plane    = plane_q;
  assign bus.shift_en    = shen_q;
  assign bus.hub75_addr  = haddr_q;
  assign bus.hub75_latch = latch_q;
  assign bus.hub75_oe    = oe_q;
  assign bus.frame_start = fs_q;
  assign bus.swap_ack    = ack_q;
  assign bus.display_buf = disp_q;

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// Bench for hub75_scan_scheduler: per-row measurement table, directed
// sequences for swap / enable / reset corners, randomized run, and a
// cycle-position reference model checking every output on every cycle.
module tb_hub75_scan_scheduler;

  localparam int unsigned COLS = 64, ROW_BITS = 4, PLANES = 4, BRIGHT_BITS = 8;
  localparam int unsigned COL_W = 6, PW = 2, ROWS = 16;
  localparam int unsigned MW = 2 + ROW_BITS + COL_W + PW + 1 + ROW_BITS + 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hub75_scan_scheduler_if #(.COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES),
                            .BRIGHT_BITS(BRIGHT_BITS)) bus ();

  hub75_scan_scheduler #(.COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES),
                         .BRIGHT_BITS(BRIGHT_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Position t counts cycles from SHIFT entry of the current plane.
  int m_valid = 0, m_idle = 1, m_t = 0, m_row = 0, m_plane = 0, m_b = 0;
  int m_pend = 0, m_disp = 0, m_haddr = 0, m_ack = 0;
  int m_on, m_len, m_col;
  logic e_sh, e_lat, e_oe, e_fs;
  logic [MW-1:0] m_exp, m_act;

  always @(negedge clk) begin
    m_on  = (m_b + 1) << m_plane;
    m_len = COLS + 3 + m_on;
    if (m_valid != 0) begin
      m_col = (m_idle == 0 && m_t < COLS) ? m_t : 0;
      e_sh  = (m_idle == 0) && (m_t >= 1) && (m_t <= COLS);
      e_lat = (m_idle == 0) && (m_t == COLS + 1);
      e_oe  = !((m_idle == 0) && (m_t >= COLS + 2) && (m_t < COLS + 2 + m_on));
      e_fs  = (m_idle == 0) && (m_t == 0) && (m_plane == 0) && (m_row == 0);
      m_exp = {m_ack[0], m_disp[0], ROW_BITS'(m_row), COL_W'(m_col), PW'(m_plane), e_sh,
               ROW_BITS'(m_haddr), e_lat, e_oe, e_fs};
      m_act = {bus.swap_ack, bus.display_buf, bus.rd_addr, bus.rd_plane, bus.shift_en,
               bus.hub75_addr, bus.hub75_latch, bus.hub75_oe, bus.frame_start};
      total++;
      if (m_act !== m_exp) begin
        bad++;
        $display("FAIL model t=%0d row=%0d plane=%0d: got %h expected %h",
                 m_t, m_row, m_plane, m_act, m_exp);
      end
    end
    m_ack = 0;
    if (reset) begin
      m_valid = 1; m_idle = 1; m_t = 0; m_row = 0; m_plane = 0;
      m_pend = 0; m_disp = 0; m_haddr = 0;
    end else if (m_valid != 0) begin
      if (bus.swap_req) m_pend = 1;
      if (m_idle != 0) begin
        if (bus.enable) begin
          m_idle = 0; m_t = 0; m_row = 0; m_plane = 0; m_b = int'(bus.brightness);
        end
      end else begin
        if (m_t == COLS) m_haddr = m_row;
        if (m_t == m_len - 1) begin
          if (m_plane == PLANES - 1) begin
            m_plane = 0;
            if (m_row == ROWS - 1) begin
              m_row = 0;
              if (m_pend != 0) begin m_disp ^= 1; m_ack = 1; m_pend = 0; end
            end else m_row++;
          end else m_plane++;
          if (bus.enable) begin m_t = 0; m_b = int'(bus.brightness); end
          else m_idle = 1;
        end else m_t++;
      end
    end
  end

  // ---------------- per-row measurement table ----------------
  typedef struct packed {
    logic [7:0]       bright;
    logic [3:0][11:0] w;       // OE-low width of plane 3..0
    logic [15:0]      row_len; // cycles from plane-0 latch to next row's
  } vec_t;
  vec_t tbl [4];

  int n, nl, acks, act, w, sh, col_err, c;
  int lat_cyc [5];
  int shc [5];
  int widths [4];
  int nw, run;
  logic [ROW_BITS+COL_W-1:0] prev_addr;

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.brightness = '0; bus.swap_req = 1'b0;

    tbl[0].bright = 8'd0;   tbl[0].w = {12'd8, 12'd4, 12'd2, 12'd1};          tbl[0].row_len = 16'd283;
    tbl[1].bright = 8'd1;   tbl[1].w = {12'd16, 12'd8, 12'd4, 12'd2};         tbl[1].row_len = 16'd298;
    tbl[2].bright = 8'd7;   tbl[2].w = {12'd64, 12'd32, 12'd16, 12'd8};       tbl[2].row_len = 16'd388;
    tbl[3].bright = 8'd255; tbl[3].w = {12'd2048, 12'd1024, 12'd512, 12'd256}; tbl[3].row_len = 16'd4108;

    tick(); tick();
    check("rst_ctrl", {26'b0, bus.hub75_oe, bus.hub75_latch, bus.shift_en, bus.swap_ack,
                       bus.frame_start, bus.display_buf}, 32'b100000);
    check("rst_rd_addr", 32'(bus.rd_addr), 0);
    check("rst_rd_plane", 32'(bus.rd_plane), 0);
    check("rst_hub75_addr", 32'(bus.hub75_addr), 0);

    for (int i = 0; i < 4; i++) begin
      bus.enable = 1'b0; bus.brightness = tbl[i].bright; reset = 1'b1;
      tick(); tick();
      reset = 1'b0; bus.enable = 1'b1;
      nl = 0; nw = 0; run = 0; sh = 0; col_err = 0; prev_addr = '0;
      for (c = 0; c < 6000 && nl < 5; c++) begin
        tick();
        if (bus.shift_en) begin
          if (int'(prev_addr[COL_W-1:0]) != sh) col_err++;
          sh++;
        end
        if (!bus.hub75_oe) run++;
        else if (run != 0) begin
          if (nw < 4) widths[nw] = run;
          nw++; run = 0;
        end
        if (bus.hub75_latch) begin lat_cyc[nl] = c; shc[nl] = sh; sh = 0; nl++; end
        prev_addr = bus.rd_addr;
      end
      check("tbl_latches", nl, 5);
      if (nl == 5) begin
        for (int p = 0; p < 4; p++) begin
          check("tbl_oe_width", widths[p], 32'(tbl[i].w[p]));
          check("tbl_shift_cnt", shc[p], COLS);
        end
        check("tbl_row_len", lat_cyc[4] - lat_cyc[0], 32'(tbl[i].row_len));
        check("tbl_col_order", col_err, 0);
      end
    end

    // frame_start one cycle after reset, then every 4528 cycles
    bus.brightness = '0; bus.enable = 1'b1; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("fs_cycle1", 32'(bus.frame_start), 1);
    n = 0;
    do begin tick(); n++; end while (!bus.frame_start && n < 6000);
    check("frame_period", n, 4528);

    // mid-frame swap request: one flip at frame end, none the frame after
    repeat (1000) tick();
    bus.swap_req = 1'b1; tick(); bus.swap_req = 1'b0;
    n = 0;
    while (!bus.swap_ack && n < 6000) begin tick(); n++; end
    check("swap_ack_seen", 32'(bus.swap_ack), 1);
    check("swap_at_frame_end", 32'(bus.frame_start), 1);
    check("swap_buf", 32'(bus.display_buf), 1);
    tick();
    check("swap_ack_single", 32'(bus.swap_ack), 0);
    acks = 0; n = 0;
    while (!bus.frame_start && n < 6000) begin
      if (bus.swap_ack) acks++;
      tick(); n++;
    end
    check("next_frame_seen", 32'(bus.frame_start), 1);
    check("no_second_ack", acks + int'(bus.swap_ack), 0);
    check("buf_held", 32'(bus.display_buf), 1);

    // request raised exactly on the frame-end BLANK cycle
    repeat (4527) tick();
    check("blank_oe", 32'(bus.hub75_oe), 1);
    bus.swap_req = 1'b1; tick(); bus.swap_req = 1'b0;
    check("blank_swap_ack", 32'(bus.swap_ack), 1);
    check("blank_swap_fs", 32'(bus.frame_start), 1);
    check("blank_swap_buf", 32'(bus.display_buf), 0);

    // enable dropped in DISPLAY of plane 2
    nl = 0; n = 0;
    while (nl < 3 && n < 1000) begin tick(); n++; if (bus.hub75_latch) nl++; end
    check("p2_latch", nl, 3);
    tick();
    check("p2_display", 32'(bus.hub75_oe), 0);
    bus.enable = 1'b0;
    w = 1; n = 0;
    while (n < 100) begin tick(); n++; if (bus.hub75_oe) break; w++; end
    check("p2_oe_width", w, 4);
    act = 0;
    repeat (300) begin
      tick();
      if (bus.shift_en || bus.hub75_latch || !bus.hub75_oe || bus.frame_start) act++;
    end
    check("idle_quiet", act, 0);

    // reset in DISPLAY of row 1 discards a pending swap
    bus.enable = 1'b1;
    tick();
    check("restart_fs", 32'(bus.frame_start), 1);
    bus.swap_req = 1'b1; tick(); bus.swap_req = 1'b0;
    n = 0;
    while (!bus.swap_ack && n < 6000) begin tick(); n++; end
    check("pre_rst_buf", 32'(bus.display_buf), 1);
    bus.swap_req = 1'b1; tick(); bus.swap_req = 1'b0;
    nl = 0; n = 0;
    while (n < 2000) begin
      tick(); n++;
      if (bus.hub75_latch) nl++;
      if (nl >= 6 && !bus.hub75_oe) break;
    end
    check("pre_rst_row", 32'(bus.hub75_addr), 1);
    reset = 1'b1; tick();
    check("rst_oe", 32'(bus.hub75_oe), 1);
    check("rst_buf", 32'(bus.display_buf), 0);
    check("rst_outs", {24'b0, bus.hub75_latch, bus.shift_en, bus.swap_ack, bus.frame_start,
                       bus.hub75_addr}, 0);
    check("rst_addr", {20'b0, bus.rd_addr, bus.rd_plane}, 0);
    reset = 1'b0;
    tick();
    check("post_rst_fs", 32'(bus.frame_start), 1);
    acks = 0; n = 0;
    do begin tick(); n++; if (bus.swap_ack) acks++; end while (!bus.frame_start && n < 6000);
    check("pending_dropped", acks, 0);
    check("post_rst_buf", 32'(bus.display_buf), 0);

    // randomized run, covered by the reference model
    bus.brightness = 8'd3;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 199) == 0) bus.brightness = BRIGHT_BITS'($urandom_range(0, 15));
      bus.swap_req = ($urandom_range(0, 2999) == 0);
      if (!bus.enable) bus.enable = ($urandom_range(0, 19) == 0);
      else if ($urandom_range(0, 4999) == 0) bus.enable = 1'b0;
      tick();
    end
    bus.swap_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hub75_scan_scheduler.md
# hub75_scan_scheduler

Sequences HUB75 panel refresh using binary-coded modulation (BCM). For each row and each bit-plane, it issues frame-RAM read addresses and a gated shift enable, then pulses latch and holds OE low for an on-time weighted by plane and global brightness. It also owns the double-buffer flip, honouring write-side swap requests only at frame boundaries. It sits between the dual-port frame RAM read side and the HUB75 output pins, replacing the free-running compare-per-intensity scan.

## Interface
Parameters:
- COLS, 64: pixels per shifted row
- ROW_BITS, 4: row address width (16 scan rows)
- PLANES, 4: BCM bit-planes per colour, MSB-aligned to the 4-bit colour fields
- BRIGHT_BITS, 8: global brightness width

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  run refresh; sampled at plane boundaries
- brightness  in  BRIGHT_BITS  global on-time scale; sampled on SHIFT entry
- swap_req  in  1  back buffer complete (pulse or level)
- swap_ack  out  1  one-cycle pulse when display_buf toggles
- display_buf  out  1  buffer half being displayed (RAM address MSB)
- rd_addr  out  ROW_BITS+clog2(COLS)  {row, col} to frame RAM
- rd_plane  out  clog2(PLANES)  plane index for the pixel bit-slicer
- shift_en  out  1  pixel-clock gate, aligned to RAM read data
- hub75_addr  out  ROW_BITS  panel row select
- hub75_latch  out  1  active-high latch
- hub75_oe  out  1  active-low output enable
- frame_start  out  1  one-cycle pulse at row 0 / plane 0 SHIFT entry

## Operation
- FSM states: IDLE, SHIFT, DRAIN, LATCH, DISPLAY, BLANK.
- IDLE: if enable, go to SHIFT with row=0, plane=0, and pulse frame_start.
- SHIFT: COLS cycles; col runs 0..COLS-1 on rd_addr. After col=COLS-1, go to DRAIN.
- DRAIN: 1 cycle, covering the last column's RAM latency. Then go to LATCH.
- LATCH: hub75_latch=1 and hub75_addr<=row for 1 cycle. Load on_time = (brightness+1) << plane, 12 bits, no overflow at maximum. Then go to DISPLAY.
- DISPLAY: hub75_oe=0 for exactly on_time cycles. Then go to BLANK.
- BLANK: hub75_oe=1 for 1 cycle, then advance:
  - plane+1; on wrap, row+1.
  - On row wrap (frame end): if swap pending, toggle display_buf and pulse swap_ack.
  - Then go to SHIFT if enable is high, else IDLE.
- Swap tracking:
  - A swap_req high on any cycle sets a sticky pending flag; swap_ack clears it.
  - swap_req asserted on the frame-end BLANK cycle is taken in that same flip.
- enable low mid-plane: the current plane completes through BLANK.
- Reset (any cycle, including mid-DISPLAY) forces these values on the next edge:
  - state=IDLE, row=0, plane=0, pending=0
  - hub75_oe=1, hub75_latch=0, shift_en=0, swap_ack=0, frame_start=0
  - hub75_addr=0, rd_addr=0, rd_plane=0, display_buf=0

## Timing
- shift_en is SHIFT-state validity delayed 1 cycle, matching RAM read latency of 1.
- shift_en is high for exactly COLS consecutive cycles per plane.
- rd_plane is stable from SHIFT entry through BLANK.
- hub75_latch is never high while hub75_oe=0. hub75_addr changes only while hub75_oe=1.
- Per-plane cycles = COLS + 3 + ((brightness+1) << plane).
- COLS=64, brightness=0:
  - plane cycles: 68, 69, 71, 75
  - 283 cycles per row, 4528 per frame
- brightness change mid-plane takes effect from the next SHIFT entry.

## Structure
- hub75_pkg holds:
  - state enum
  - default COLS, ROW_BITS, PLANES constants
  - ON_TIME_W = BRIGHT_BITS + PLANES
- Sub-module hub75_on_timer: loadable ON_TIME_W down-counter with a done flag, used by DISPLAY.

## Test plan
- Reset, enable=1, brightness=0: frame_start at cycle 1; 4528 cycles between frame_start pulses; OE low widths 1, 2, 4, 8.
- brightness=255: plane-3 OE low for exactly 2048 cycles; each plane has 64 shift_en cycles, rd_addr col 0..63.
- swap_req pulse mid-frame: display_buf toggles and a single swap_ack pulses on the frame-end BLANK; no toggle on the following frame.
- swap_req on the frame-end BLANK cycle: flip occurs that frame.
- enable dropped during DISPLAY of plane 2: BLANK completes, then IDLE with hub75_oe=1 and no further shift_en.
- reset during DISPLAY: next cycle hub75_oe=1, state IDLE, display_buf=0; a pending swap is discarded.
